// File: rtl/cpu_mc_pkg.sv
// cpu_mc_pkg: shared FSM states, RV32I opcodes, load-size/writeback-select encodings and ALU/branch helpers
package cpu_mc_pkg;
    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_WB} state_t;
    typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4} wb_sel_t;
    localparam logic [1:0] LS_B = 2'd0;
    localparam logic [1:0] LS_H = 2'd1;
    localparam logic [1:0] LS_W = 2'd2;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_JAL    = 7'h6f;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_OP     = 7'h33;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    function automatic logic [31:0] alu_op(input logic [2:0] f3, input logic alt,
                                           input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'b000:  return alt ? a - b : a + b;
            3'b001:  return a << b[4:0];
            3'b010:  return {31'd0, $signed(a) < $signed(b)};
            3'b011:  return {31'd0, a < b};
            3'b100:  return a ^ b;
            3'b101:  return alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'b110:  return a | b;
            default: return a & b;
        endcase
    endfunction

    // f3[0] inverts the base comparison (ne/ge/geu)
    function automatic logic br_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic r;
        r = f3[2] ? (f3[1] ? a < b : $signed(a) < $signed(b)) : a == b;
        return r ^ f3[0];
    endfunction
endpackage

// File: rtl/cpu_mc_lsu_align.sv
// lsu_align: byte-lane alignment for loads/stores
// Ports: i_addr effective address, i_size LS_B/LS_H/LS_W, i_unsigned zero-extend loads,
//        i_wdata store data, i_rdata raw read word; o_addr word address, o_wdata lane-shifted
//        store data, o_wmask byte strobes, o_rdata extracted and extended load data
module lsu_align
    import cpu_mc_pkg::*;
(
    input  logic [31:0] i_addr,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_addr,
    output logic [31:0] o_wdata,
    output logic [3:0]  o_wmask,
    output logic [31:0] o_rdata
);
    logic [1:0]  w_lane;
    logic [31:0] w_sh;

    // lane comes from the naturally aligned address, so misaligned halves/words snap down
    assign w_lane  = (i_size == LS_B) ? i_addr[1:0] : (i_size == LS_H) ? {i_addr[1], 1'b0} : 2'b00;
    assign o_addr  = {i_addr[31:2], 2'b00};
    assign o_wdata = i_wdata << {w_lane, 3'b000};
    assign o_wmask = ((i_size == LS_B) ? 4'b0001 : (i_size == LS_H) ? 4'b0011 : 4'b1111) << w_lane;
    assign w_sh    = i_rdata >> {w_lane, 3'b000};
    assign o_rdata = (i_size == LS_B) ? {{24{!i_unsigned && w_sh[7]}}, w_sh[7:0]} :
                     (i_size == LS_H) ? {{16{!i_unsigned && w_sh[15]}}, w_sh[15:0]} : w_sh;
endmodule

// File: rtl/cpu_mc.sv
// cpu_mc: multi-cycle RV32I core (FETCH/EXEC/MEM/WB), without FENCE/ECALL/EBREAK/CSR
// Ports: i_clk/i_rst; o_imem_req/o_imem_addr/i_imem_ack/i_imem_rdata instruction port;
//        o_dmem_req/o_dmem_we/o_dmem_addr/o_dmem_wdata/o_dmem_wmask/i_dmem_ack/i_dmem_rdata data port;
//        o_pc architectural PC, o_retire retire pulse, o_cycle/o_instret performance counters
// Macro RISKY_PERF_CNT_EN adds the counters; otherwise they read as zero.
module cpu_mc
    import cpu_mc_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          CNT_WIDTH    = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    output logic                 o_imem_req,
    output logic [31:0]          o_imem_addr,
    input  logic                 i_imem_ack,
    input  logic [31:0]          i_imem_rdata,
    output logic                 o_dmem_req,
    output logic                 o_dmem_we,
    output logic [31:0]          o_dmem_addr,
    output logic [31:0]          o_dmem_wdata,
    output logic [3:0]           o_dmem_wmask,
    input  logic                 i_dmem_ack,
    input  logic [31:0]          i_dmem_rdata,
    output logic [31:0]          o_pc,
    output logic                 o_retire,
    output logic [CNT_WIDTH-1:0] o_cycle,
    output logic [CNT_WIDTH-1:0] o_instret
);
    state_t      r_state, w_next;
    logic        r_hold;
    logic [31:0] r_pc, r_ir, r_ld;
    logic [31:0] r_regs [0:31];
    logic [6:0]  w_op;
    logic [4:0]  w_rd, w_rs1, w_rs2;
    logic [2:0]  w_f3;
    logic [31:0] w_rs1v, w_rs2v, w_imm, w_a, w_b, w_res, w_pc4, w_npc, w_wbv, w_ld;
    logic        w_alt, w_taken, w_wb_we;
    wb_sel_t     w_wb_sel;

    // IR, PC and registers are frozen from EXEC through WB, so the decode stays combinational
    assign w_op   = r_ir[6:0];
    assign w_rd   = r_ir[11:7];
    assign w_f3   = r_ir[14:12];
    assign w_rs1  = r_ir[19:15];
    assign w_rs2  = r_ir[24:20];
    assign w_rs1v = (w_rs1 == 5'd0) ? 32'd0 : r_regs[w_rs1];
    assign w_rs2v = (w_rs2 == 5'd0) ? 32'd0 : r_regs[w_rs2];
    assign w_imm  = (w_op == OP_LUI || w_op == OP_AUIPC) ? {r_ir[31:12], 12'd0} :
                    (w_op == OP_STORE)  ? {{20{r_ir[31]}}, r_ir[31:25], r_ir[11:7]} :
                    (w_op == OP_BRANCH) ? {{20{r_ir[31]}}, r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0} :
                    (w_op == OP_JAL)    ? {{12{r_ir[31]}}, r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0} :
                                          {{20{r_ir[31]}}, r_ir[31:20]};
    assign w_a      = (w_op == OP_AUIPC) ? r_pc : w_rs1v;
    assign w_b      = (w_op == OP_OP) ? w_rs2v : w_imm;
    // bit 30 selects SUB only for register ops, SRA/SRAI for both
    assign w_alt    = r_ir[30] && (w_op == OP_OP || w_f3 == 3'b101);
    assign w_res    = (w_op == OP_LUI) ? w_imm :
                      (w_op == OP_OP || w_op == OP_IMM) ? alu_op(w_f3, w_alt, w_a, w_b) : w_a + w_b;
    assign w_taken  = (w_op == OP_BRANCH) && br_taken(w_f3, w_rs1v, w_rs2v);
    assign w_pc4    = r_pc + 32'd4;
    assign w_npc    = (w_op == OP_JALR) ? {w_res[31:1], 1'b0} :
                      (w_op == OP_JAL || w_taken) ? r_pc + w_imm : w_pc4;
    assign w_wb_sel = (w_op == OP_LOAD) ? WB_MEM : (w_op == OP_JAL || w_op == OP_JALR) ? WB_PC4 : WB_ALU;
    assign w_wb_we  = w_op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_IMM, OP_OP};
    assign w_wbv    = (w_wb_sel == WB_MEM) ? r_ld : (w_wb_sel == WB_PC4) ? w_pc4 : w_res;

    lsu_align u_lsu (
        .i_addr    (w_res),
        .i_size    (w_f3[1:0]),
        .i_unsigned(w_f3[2]),
        .i_wdata   (w_rs2v),
        .i_rdata   (i_dmem_rdata),
        .o_addr    (o_dmem_addr),
        .o_wdata   (o_dmem_wdata),
        .o_wmask   (o_dmem_wmask),
        .o_rdata   (w_ld)
    );

    assign o_imem_addr = r_pc;
    assign o_pc        = r_pc;
    assign o_dmem_we   = (w_op == OP_STORE);

    // r_hold keeps both requests low for the cycle after reset, so stale acks are dropped
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_FETCH;
            r_hold  <= 1'b1;
        end else begin
            r_state <= w_next;
            r_hold  <= 1'b0;
        end
    end

    always_comb begin
        w_next     = r_state;
        o_imem_req = 1'b0;
        o_dmem_req = 1'b0;
        o_retire   = 1'b0;
        case (r_state)
            S_FETCH: begin
                o_imem_req = !r_hold;
                w_next     = (!r_hold && i_imem_ack) ? S_EXEC : S_FETCH;
            end
            S_EXEC: w_next = (w_op == OP_LOAD || w_op == OP_STORE) ? S_MEM : S_WB;
            S_MEM: begin
                o_dmem_req = 1'b1;
                w_next     = i_dmem_ack ? S_WB : S_MEM;
            end
            default: begin
                o_retire = !i_rst;
                w_next   = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc <= RESET_VECTOR;
            r_ir <= NOP;
        end else begin
            if (o_imem_req && i_imem_ack) r_ir <= i_imem_rdata;
            if (o_retire) r_pc <= w_npc;
        end
    end

    always_ff @(posedge i_clk) begin
        if (o_dmem_req && i_dmem_ack) r_ld <= w_ld;
        if (o_retire && w_wb_we && w_rd != 5'd0) r_regs[w_rd] <= w_wbv;
    end

`ifdef RISKY_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] r_cycle, r_instret;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cycle   <= '0;
            r_instret <= '0;
        end else begin
            r_cycle <= r_cycle + CNT_WIDTH'(1);
            if (o_retire) r_instret <= r_instret + CNT_WIDTH'(1);
        end
    end

    assign o_cycle   = r_cycle;
    assign o_instret = r_instret;
`else
    assign o_cycle   = '0;
    assign o_instret = '0;
`endif
endmodule

// File: tb/tb_cpu_mc.sv
// tb_cpu_mc: directed table-driven bench for cpu_mc with hand-computed expectations
module tb_cpu_mc;
    logic        clk = 1'b0, rst = 1'b1;
    logic        imem_req, imem_ack = 1'b0, dmem_req, dmem_we, dmem_ack = 1'b0, retire;
    logic [31:0] imem_addr, imem_rdata = 32'd0, dmem_addr, dmem_wdata, dmem_rdata = 32'd0, pc;
    logic [3:0]  dmem_wmask;
    logic [31:0] cyc, instret;
    int          passed = 0, total = 0;

    typedef struct {
        logic [31:0] instr;
        int          fd;
        int          dd;
        int          lat;
        logic [31:0] npc;
        logic        mem;
        logic        we;
        logic [31:0] daddr;
        logic [3:0]  mask;
        logic [31:0] wdata;
    } vec_t;

    vec_t v [27];

    always #5 clk = ~clk;

    cpu_mc dut (
        .i_clk(clk), .i_rst(rst),
        .o_imem_req(imem_req), .o_imem_addr(imem_addr), .i_imem_ack(imem_ack), .i_imem_rdata(imem_rdata),
        .o_dmem_req(dmem_req), .o_dmem_we(dmem_we), .o_dmem_addr(dmem_addr), .o_dmem_wdata(dmem_wdata),
        .o_dmem_wmask(dmem_wmask), .i_dmem_ack(dmem_ack), .i_dmem_rdata(dmem_rdata),
        .o_pc(pc), .o_retire(retire), .o_cycle(cyc), .o_instret(instret)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    always @(negedge clk) if (!rst && imem_req && dmem_req) chk("req_exclusive", 32'd1, 32'd0);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
    endfunction
    function automatic vec_t mk(input logic [31:0] instr, input int fd, input int dd, input int lat,
                                input logic [31:0] npc, input logic mem, input logic we,
                                input logic [31:0] daddr, input logic [3:0] mask, input logic [31:0] wdata);
        vec_t r;
        r.instr = instr; r.fd = fd; r.dd = dd; r.lat = lat; r.npc = npc;
        r.mem = mem; r.we = we; r.daddr = daddr; r.mask = mask; r.wdata = wdata;
        return r;
    endfunction

    // Serves one instruction: fetch after fd wait cycles, data after dd wait cycles (read word 0x0080FF00).
    // lat counts cycles from the first request cycle through the retire cycle inclusive.
    task automatic run(input logic [31:0] instr, input int fd, input int dd, output int lat,
                       output logic [31:0] faddr, output logic hold, output logic seen,
                       output logic [31:0] daddr, output logic [31:0] wdata, output logic we,
                       output logic [3:0] mask);
        int n;
        lat = 0; hold = 1'b1; seen = 1'b0; daddr = 0; wdata = 0; we = 1'b0; mask = 0; n = 0;
        while (!imem_req && n < 8) begin step(); n++; end
        faddr = imem_addr;
        for (int i = 0; i < fd; i++) begin
            if (!imem_req || imem_addr !== faddr) hold = 1'b0;
            step(); lat++;
        end
        if (!imem_req || imem_addr !== faddr) hold = 1'b0;
        imem_ack = 1'b1; imem_rdata = instr;
        step(); lat++;
        imem_ack = 1'b0;
        n = 0;
        while (!retire && n < 30) begin
            if (dmem_req) begin
                seen = 1'b1; daddr = dmem_addr; wdata = dmem_wdata; we = dmem_we; mask = dmem_wmask;
                for (int i = 0; i < dd; i++) begin
                    if (!dmem_req || dmem_addr !== daddr || dmem_wdata !== wdata || dmem_wmask !== mask || dmem_we !== we)
                        hold = 1'b0;
                    step(); lat++;
                end
                dmem_ack = 1'b1; dmem_rdata = 32'h0080FF00;
                step(); lat++;
                dmem_ack = 1'b0;
            end else begin
                step(); lat++;
            end
            n++;
        end
        lat = retire ? lat + 1 : -1;
        step();
    endtask

    initial begin
        int          lat, n;
        logic [31:0] faddr, daddr, wdata, exp_pc;
        logic        hold, seen, we;
        logic [3:0]  mask;
        v[0]  = mk(enc_i(12'd5, 5'd0, 3'd0, 5'd1, 7'h13),     0, 0, 3, 32'h04, 0, 0, 0, 0, 0);
        v[1]  = mk(enc_s(12'd0, 5'd1, 5'd0, 3'd2),             0, 0, 4, 32'h08, 1, 1, 32'h0, 4'hF, 32'h5);
        v[2]  = mk(enc_i(12'h100, 5'd0, 3'd0, 5'd2, 7'h13),   3, 0, 6, 32'h0C, 0, 0, 0, 0, 0);
        v[3]  = mk({20'hAABBD, 5'd3, 7'h37},                   0, 0, 3, 32'h10, 0, 0, 0, 0, 0);
        v[4]  = mk(enc_i(12'hCDD, 5'd3, 3'd0, 5'd3, 7'h13),   0, 0, 3, 32'h14, 0, 0, 0, 0, 0);
        v[5]  = mk(enc_s(12'd1, 5'd3, 5'd2, 3'd0),             0, 2, 6, 32'h18, 1, 1, 32'h100, 4'b0010, 32'hBBCCDD00);
        v[6]  = mk(enc_s(12'd2, 5'd3, 5'd2, 3'd1),             0, 0, 4, 32'h1C, 1, 1, 32'h100, 4'b1100, 32'hCCDD0000);
        v[7]  = mk(enc_i(12'h200, 5'd0, 3'd0, 5'd4, 7'h13),   0, 0, 3, 32'h20, 0, 0, 0, 0, 0);
        v[8]  = mk(enc_i(12'd1, 5'd4, 3'd0, 5'd5, 7'h03),     0, 0, 4, 32'h24, 1, 0, 32'h200, 0, 0);
        v[9]  = mk(enc_s(12'd0, 5'd5, 5'd0, 3'd2),             0, 0, 4, 32'h28, 1, 1, 32'h0, 4'hF, 32'hFFFFFFFF);
        v[10] = mk(enc_i(12'd1, 5'd4, 3'd4, 5'd5, 7'h03),     1, 1, 6, 32'h2C, 1, 0, 32'h200, 0, 0);
        v[11] = mk(enc_s(12'd0, 5'd5, 5'd0, 3'd2),             0, 0, 4, 32'h30, 1, 1, 32'h0, 4'hF, 32'h000000FF);
        v[12] = mk(enc_i(12'd2, 5'd4, 3'd1, 5'd5, 7'h03),     0, 0, 4, 32'h34, 1, 0, 32'h200, 0, 0);
        v[13] = mk(enc_s(12'd0, 5'd5, 5'd0, 3'd2),             0, 0, 4, 32'h38, 1, 1, 32'h0, 4'hF, 32'h00000080);
        v[14] = mk({7'h20, 5'd1, 5'd3, 3'd0, 5'd6, 7'h33},     0, 0, 3, 32'h3C, 0, 0, 0, 0, 0);
        v[15] = mk(enc_s(12'd0, 5'd6, 5'd0, 3'd2),             0, 0, 4, 32'h40, 1, 1, 32'h0, 4'hF, 32'hAABBCCD8);
        v[16] = mk(enc_i(12'd7, 5'd0, 3'd0, 5'd0, 7'h13),     0, 0, 3, 32'h44, 0, 0, 0, 0, 0);
        v[17] = mk(enc_s(12'd0, 5'd0, 5'd0, 3'd2),             0, 0, 4, 32'h48, 1, 1, 32'h0, 4'hF, 32'h0);
        v[18] = mk(enc_j(21'h1FFFC8, 5'd7),                    0, 0, 3, 32'h10, 0, 0, 0, 0, 0);
        v[19] = mk(enc_b(13'h1FF8, 5'd0, 5'd0, 3'd0),          0, 0, 3, 32'h08, 0, 0, 0, 0, 0);
        v[20] = mk(enc_i(12'h40, 5'd0, 3'd0, 5'd5, 7'h13),    0, 0, 3, 32'h0C, 0, 0, 0, 0, 0);
        v[21] = mk(enc_i(12'd3, 5'd5, 3'd0, 5'd1, 7'h67),     0, 0, 3, 32'h42, 0, 0, 0, 0, 0);
        v[22] = mk(enc_s(12'd0, 5'd1, 5'd0, 3'd2),             0, 0, 4, 32'h46, 1, 1, 32'h0, 4'hF, 32'h10);
        v[23] = mk(enc_s(12'd0, 5'd7, 5'd0, 3'd2),             0, 0, 4, 32'h4A, 1, 1, 32'h0, 4'hF, 32'h4C);
        v[24] = mk(enc_b(13'd16, 5'd0, 5'd0, 3'd1),            0, 0, 3, 32'h4E, 0, 0, 0, 0, 0);
        v[25] = mk(enc_b(13'd16, 5'd1, 5'd6, 3'd4),            0, 0, 3, 32'h5E, 0, 0, 0, 0, 0);
        v[26] = mk(enc_b(13'd16, 5'd1, 5'd6, 3'd6),            0, 0, 3, 32'h62, 0, 0, 0, 0, 0);

        step(); step();
        rst = 1'b0;
        chk("reset_pc", pc, 32'h0);
        chk("reset_imem_req", {31'd0, imem_req}, 32'd0);
        chk("reset_dmem_req", {31'd0, dmem_req}, 32'd0);
        chk("reset_retire", {31'd0, retire}, 32'd0);
        chk("reset_cycle", cyc, 32'd0);
        chk("reset_instret", instret, 32'd0);

        exp_pc = 32'h0;
        for (int k = 0; k < 27; k++) begin
            run(v[k].instr, v[k].fd, v[k].dd, lat, faddr, hold, seen, daddr, wdata, we, mask);
            chk($sformatf("v%0d fetch_addr", k), faddr, exp_pc);
            chk($sformatf("v%0d latency", k), 32'(lat), 32'(v[k].lat));
            chk($sformatf("v%0d next_pc", k), pc, v[k].npc);
            chk($sformatf("v%0d req_held_stable", k), {31'd0, hold}, 32'd1);
            chk($sformatf("v%0d mem_access", k), {31'd0, seen}, {31'd0, v[k].mem});
            if (v[k].mem) begin
                chk($sformatf("v%0d dmem_addr", k), daddr, v[k].daddr);
                chk($sformatf("v%0d dmem_we", k), {31'd0, we}, {31'd0, v[k].we});
                if (v[k].we) begin
                    chk($sformatf("v%0d dmem_wmask", k), {28'd0, mask}, {28'd0, v[k].mask});
                    chk($sformatf("v%0d dmem_wdata", k), wdata, v[k].wdata);
                end
            end
            exp_pc = v[k].npc;
        end

        // reset while a load waits in MEM: x1 (0x10) must survive, late ack must be ignored
        n = 0;
        while (!imem_req && n < 8) begin step(); n++; end
        imem_ack = 1'b1; imem_rdata = enc_i(12'd0, 5'd0, 3'd2, 5'd1, 7'h03);
        step();
        imem_ack = 1'b0;
        step();
        chk("mid_mem_dmem_req", {31'd0, dmem_req}, 32'd1);
        step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_imem_req", {31'd0, imem_req}, 32'd0);
        chk("mid_rst_dmem_req", {31'd0, dmem_req}, 32'd0);
        chk("mid_rst_pc", pc, 32'h0);
        chk("mid_rst_instret", instret, 32'd0);
        chk("mid_rst_retire", {31'd0, retire}, 32'd0);
        dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF;
        step();
        dmem_ack = 1'b0;
        run(enc_s(12'd0, 5'd1, 5'd0, 3'd2), 0, 0, lat, faddr, hold, seen, daddr, wdata, we, mask);
        chk("post_rst fetch_addr", faddr, 32'h0);
        chk("post_rst latency", 32'(lat), 32'd4);
        chk("post_rst x1_kept", wdata, 32'h10);
        chk("post_rst next_pc", pc, 32'h4);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
